// File: rtl/mem_port_arbiter_if.sv
// Two-master data-memory port bundle: pipeline (M0), loader/DMA (M1) and the
// single-ported data memory behind the arbiter.
interface mem_port_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;

    logic        m1_req;
    logic        m1_we;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic        m1_err;

    logic [31:0] rdata;

    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_rdata;

    // Arbiter side
    modport slave (
        input  m0_req, m0_we, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_err,
        output rdata,
        output mem_addr, mem_wdata, mem_read, mem_write,
        input  mem_rdata
    );

    // Requester / memory side
    modport master (
        output m0_req, m0_we, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_err,
        input  rdata,
        input  mem_addr, mem_wdata, mem_read, mem_write,
        output mem_rdata
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-master arbiter for a single data-memory port.
//
//  state | meaning
//  ------+---------------------------------------------------------------
//  ARB   | alternate between masters when both request (favour != last)
//  LOCK  | M1 owns the port back-to-back while m1_req & m1_lock, bounded
//        | by MAX_LOCK consecutive grants
//
// M1 accesses with addr[30]=1 (peripheral space) are granted but never reach
// memory; they are answered with a one-cycle m1_err instead.
module mem_port_arbiter #(
    parameter int unsigned MAX_LOCK = 8
) (
    input  logic                clk,
    input  logic                reset,
    mem_port_arbiter_if.slave   bus
);
    typedef enum logic {ST_ARB = 1'b0, ST_LOCK = 1'b1} state_t;

    localparam logic [3:0] MAX_CNT = 4'(MAX_LOCK);

    state_t     state, state_nxt;
    logic       last, last_nxt;
    logic [3:0] lock_cnt, lock_cnt_nxt;
    logic [3:0] cnt_inc;
    logic       gnt0, gnt1;
    logic       m1_periph;
    logic       lock_hold;
    logic       rd_strobe;

    assign m1_periph = bus.m1_addr[30];
    assign lock_hold = (state == ST_LOCK) && bus.m1_req && bus.m1_lock;
    assign cnt_inc   = lock_cnt + 4'd1;

    // State, last-granted and lock counter registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_ARB;
            last     <= 1'b1;
            lock_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            lock_cnt <= lock_cnt_nxt;
        end
    end

    // Next state: enter/continue LOCK only on a locked M1 memory grant
    always_comb begin
        state_nxt    = ST_ARB;
        last_nxt     = last;
        lock_cnt_nxt = 4'd0;
        if (gnt0) last_nxt = 1'b0;
        if (gnt1) last_nxt = 1'b1;
        if (gnt1 && bus.m1_lock && (lock_hold || !m1_periph)) begin
            if (cnt_inc == MAX_CNT) begin
                state_nxt    = ST_ARB;
                lock_cnt_nxt = 4'd0;
            end else begin
                state_nxt    = ST_LOCK;
                lock_cnt_nxt = cnt_inc;
            end
        end
    end

    // Outputs: grant selection and memory port mux, all forced low in reset
    always_comb begin
        gnt0          = 1'b0;
        gnt1          = 1'b0;
        rd_strobe     = 1'b0;
        bus.mem_addr  = 32'd0;
        bus.mem_wdata = 32'd0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        if (reset) begin
            if (lock_hold) begin
                gnt1 = 1'b1;
            end else if (bus.m0_req && bus.m1_req) begin
                gnt0 = last;
                gnt1 = !last;
            end else begin
                gnt0 = bus.m0_req;
                gnt1 = bus.m1_req && !bus.m0_req;
            end
        end
        if (gnt0) begin
            bus.mem_addr  = bus.m0_addr;
            bus.mem_wdata = bus.m0_wdata;
            rd_strobe     = !bus.m0_we;
            bus.mem_write = bus.m0_we;
        end else if (gnt1) begin
            bus.mem_addr  = bus.m1_addr;
            bus.mem_wdata = bus.m1_wdata;
            rd_strobe     = !bus.m1_we && !m1_periph;
            bus.mem_write = bus.m1_we && !m1_periph;
        end
        bus.mem_read = rd_strobe;
        bus.m0_gnt   = gnt0;
        bus.m1_gnt   = gnt1;
    end

    // Read-data capture and one-cycle completion flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.rdata     <= 32'd0;
            bus.m0_rvalid <= 1'b0;
            bus.m1_rvalid <= 1'b0;
            bus.m1_err    <= 1'b0;
        end else begin
            bus.m0_rvalid <= gnt0 && !bus.m0_we;
            bus.m1_rvalid <= gnt1 && !bus.m1_we && !m1_periph;
            bus.m1_err    <= gnt1 && m1_periph;
            if (rd_strobe) bus.rdata <= bus.mem_rdata;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed + random bench for mem_port_arbiter against a transaction-level
// model of the arbitration and completion rules.
module tb_mem_port_arbiter;
    localparam int MAX_LOCK = 8;

    logic clk;
    logic reset;
    mem_port_arbiter_if bus();

    mem_port_arbiter #(.MAX_LOCK(MAX_LOCK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    // reference model state
    bit          mdl_locked;
    int          mdl_run;
    int          mdl_last;
    logic [31:0] exp_rdata;
    bit          exp_v0, exp_v1, exp_err;
    int          cur_w;
    int          m1_run_len;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mdl_locked = 0;
        mdl_run    = 0;
        mdl_last   = 1;
        exp_rdata  = 32'd0;
        exp_v0     = 0;
        exp_v1     = 0;
        exp_err    = 0;
    endtask

    function automatic int pick();
        if (!reset) return -1;
        if (mdl_locked && bus.m1_req && bus.m1_lock) return 1;
        if (bus.m0_req && bus.m1_req) return (mdl_last == 0) ? 1 : 0;
        if (bus.m0_req) return 0;
        if (bus.m1_req) return 1;
        return -1;
    endfunction

    task automatic chk_all_zero(input string tag);
        chk({tag, ".m0_gnt"},    {31'd0, bus.m0_gnt},    32'd0);
        chk({tag, ".m1_gnt"},    {31'd0, bus.m1_gnt},    32'd0);
        chk({tag, ".m0_rvalid"}, {31'd0, bus.m0_rvalid}, 32'd0);
        chk({tag, ".m1_rvalid"}, {31'd0, bus.m1_rvalid}, 32'd0);
        chk({tag, ".m1_err"},    {31'd0, bus.m1_err},    32'd0);
        chk({tag, ".rdata"},     bus.rdata,              32'd0);
        chk({tag, ".mem_addr"},  bus.mem_addr,           32'd0);
        chk({tag, ".mem_wdata"}, bus.mem_wdata,          32'd0);
        chk({tag, ".mem_read"},  {31'd0, bus.mem_read},  32'd0);
        chk({tag, ".mem_write"}, {31'd0, bus.mem_write}, 32'd0);
    endtask

    // One clock: check this cycle's outputs against the model, then advance.
    task automatic step();
        int          w;
        logic [31:0] e_addr, e_wdata;
        bit          e_rd, e_wr, periph, we;
        #3;
        w = pick();
        cur_w = w;
        e_addr = 32'd0; e_wdata = 32'd0; e_rd = 0; e_wr = 0; periph = 0; we = 0;
        if (w == 0) begin
            e_addr = bus.m0_addr; e_wdata = bus.m0_wdata; we = bus.m0_we;
        end else if (w == 1) begin
            e_addr = bus.m1_addr; e_wdata = bus.m1_wdata; we = bus.m1_we;
            periph = bus.m1_addr[30];
        end
        if (w >= 0 && !periph) begin
            e_rd = !we;
            e_wr = we;
        end
        chk("m0_gnt",    {31'd0, bus.m0_gnt},    {31'd0, w == 0});
        chk("m1_gnt",    {31'd0, bus.m1_gnt},    {31'd0, w == 1});
        chk("mem_addr",  bus.mem_addr,           e_addr);
        chk("mem_wdata", bus.mem_wdata,          e_wdata);
        chk("mem_read",  {31'd0, bus.mem_read},  {31'd0, e_rd});
        chk("mem_write", {31'd0, bus.mem_write}, {31'd0, e_wr});
        chk("m0_rvalid", {31'd0, bus.m0_rvalid}, {31'd0, exp_v0});
        chk("m1_rvalid", {31'd0, bus.m1_rvalid}, {31'd0, exp_v1});
        chk("m1_err",    {31'd0, bus.m1_err},    {31'd0, exp_err});
        chk("rdata",     bus.rdata,              exp_rdata);

        // advance model to the state after this edge
        exp_v0 = 0; exp_v1 = 0; exp_err = 0;
        if (e_rd) exp_rdata = bus.mem_rdata;
        if (w == 0) begin
            mdl_last = 0;
            exp_v0 = !we;
            mdl_locked = 0; mdl_run = 0;
        end else if (w == 1) begin
            mdl_last = 1;
            exp_err = periph;
            exp_v1 = !we && !periph;
            if (bus.m1_lock && (mdl_locked || !periph)) begin
                mdl_run++;
                if (mdl_run == MAX_LOCK) begin
                    mdl_locked = 0; mdl_run = 0;
                end else begin
                    mdl_locked = 1;
                end
            end else begin
                mdl_locked = 0; mdl_run = 0;
            end
        end else begin
            mdl_locked = 0; mdl_run = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
        bus.m1_req = 0; bus.m1_we = 0; bus.m1_lock = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
        bus.mem_rdata = 0;
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        model_reset();
        @(posedge clk); #1;
        chk_all_zero("reset");
        @(posedge clk); #1;
        reset = 1'b1;

        // M0 read of 0x10
        bus.m0_req = 1; bus.m0_addr = 32'h10; bus.mem_rdata = 32'h12345678;
        step();
        idle_inputs();
        step();
        chk("m0_read.rdata", bus.rdata, 32'h12345678);

        // M0 write to peripheral space passes through
        bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h40000010; bus.m0_wdata = 32'hA5;
        bus.mem_rdata = 32'hDEADBEEF;
        step();
        idle_inputs();

        // M1 write to peripheral space is rejected
        bus.m1_req = 1; bus.m1_we = 1; bus.m1_addr = 32'h40000010; bus.m1_wdata = 32'h5A;
        step();
        idle_inputs();
        step();
        step();

        // M1 locked read of peripheral space must not enter LOCK
        bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h40000020;
        step();
        idle_inputs();
        step();

        // both requesting, unlocked: strict alternation
        bus.m0_req = 1; bus.m0_addr = 32'h100;
        bus.m1_req = 1; bus.m1_addr = 32'h200;
        for (int i = 0; i < 6; i++) begin
            bus.mem_rdata = $urandom;
            step();
        end
        idle_inputs();
        step();

        // locked burst against a competing M0: bounded ownership
        m1_run_len = 0;
        bus.m0_req = 1; bus.m0_addr = 32'h300;
        bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h400;
        for (int i = 0; i < 12; i++) begin
            bus.mem_rdata = $urandom;
            step();
            if (cur_w == 1) m1_run_len++;
            else if (m1_run_len > 0) begin
                chk("lock_burst_len", m1_run_len, MAX_LOCK);
                m1_run_len = -100;
            end
        end
        idle_inputs();
        step();

        // reset mid-LOCK
        bus.m0_req = 1; bus.m1_req = 1; bus.m1_lock = 1; bus.m1_addr = 32'h500;
        step(); step(); step();
        #2;
        reset = 1'b0;
        #1;
        chk_all_zero("mid_lock_reset");
        model_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        step();
        chk("post_reset_first", {30'd0, cur_w == 0, cur_w == 1}, 32'd2);
        idle_inputs();

        // random traffic honouring the hold-until-granted rule
        for (int i = 0; i < 400; i++) begin
            bit hold0, hold1;
            hold0 = bus.m0_req && (cur_w != 0);
            hold1 = bus.m1_req && (cur_w != 1);
            if (!hold0) begin
                bus.m0_req   = ($urandom_range(0, 3) != 0);
                bus.m0_we    = $urandom_range(0, 1);
                bus.m0_addr  = $urandom;
                bus.m0_wdata = $urandom;
            end
            if (!hold1) begin
                bus.m1_req   = ($urandom_range(0, 3) != 0);
                bus.m1_we    = $urandom_range(0, 1);
                bus.m1_lock  = ($urandom_range(0, 2) != 0);
                bus.m1_addr  = $urandom;
                bus.m1_addr[30] = ($urandom_range(0, 3) == 0);
                bus.m1_wdata = $urandom;
            end
            bus.mem_rdata = $urandom;
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter: MAX_LOCK, default 8, maximum consecutive locked M1 grants (1..15).
REQ-002 SHALL have port: clk  in  1  sole clock, rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-004 SHALL have port: m0_req  in  1  pipeline (M0) access request.
REQ-005 SHALL have port: m0_we  in  1  M0 write (1) / read (0).
REQ-006 SHALL have port: m0_addr  in  32  M0 byte address.
REQ-007 SHALL have port: m0_wdata  in  32  M0 write data.
REQ-008 SHALL have port: m0_gnt  out  1  M0 granted this cycle.
REQ-009 SHALL have port: m0_rvalid  out  1  M0 read data valid on rdata.
REQ-010 SHALL have port: m1_req  in  1  loader/DMA (M1) access request.
REQ-011 SHALL have port: m1_we  in  1  M1 write (1) / read (0).
REQ-012 SHALL have port: m1_lock  in  1  M1 requests back-to-back ownership.
REQ-013 SHALL have port: m1_addr  in  32  M1 byte address.
REQ-014 SHALL have port: m1_wdata  in  32  M1 write data.
REQ-015 SHALL have port: m1_gnt  out  1  M1 granted this cycle.
REQ-016 SHALL have port: m1_rvalid  out  1  M1 read data valid on rdata.
REQ-017 SHALL have port: m1_err  out  1  M1 access rejected (peripheral space).
REQ-018 SHALL have port: rdata  out  32  registered read data, shared by both masters.
REQ-019 SHALL have port: mem_addr  out  32  address to data memory.
REQ-020 SHALL have port: mem_wdata  out  32  write data to data memory.
REQ-021 SHALL have port: mem_read  out  1  memory read strobe.
REQ-022 SHALL have port: mem_write  out  1  memory write strobe (committed at rising clk).
REQ-023 SHALL have port: mem_rdata  in  32  combinational memory read data.

Function
REQ-024 SHALL grant at most one master per cycle; gnt combinational from req and state; a transfer completes at the rising edge where its gnt=1; requester holds req/we/addr/wdata until that edge.
REQ-025 SHALL drive mem_addr/mem_wdata from winner, mem_read=gnt&~we, mem_write=gnt&we; no grant -> mem_read=mem_write=0, mem_addr=mem_wdata=0.
REQ-026 SHALL implement FSM ARB/LOCK plus 1-bit last (last granted master) and 4-bit lock_cnt.
REQ-027 ARB: single requester wins; both requesting -> master != last wins; last updates on every grant.
REQ-028 ARB: M1 granted with m1_lock=1 and m1_addr[30]=0 -> LOCK, lock_cnt=1.
REQ-029 LOCK: m1_req&m1_lock -> M1 granted, M0 blocked, lock_cnt+1; m1_req=0 or m1_lock=0 -> ARB same cycle (arbitrate as ARB).
REQ-030 LOCK: grant making lock_cnt=MAX_LOCK -> ARB, last=1, lock_cnt=0; M0, if requesting, wins next cycle.
REQ-031 Read completion: rdata<=mem_rdata at grant edge; requester's rvalid=1 for exactly the next cycle; rdata holds otherwise.
REQ-032 m1_addr[30]=1: M1 granted, both mem strobes 0, m1_err=1 next cycle only, m1_rvalid=0, rdata unchanged, no LOCK entry.
REQ-033 M0 has no address restriction; peripheral-space (addr[30]=1) accesses pass through.
REQ-034 Writes: no rvalid, rdata unchanged.

Reset
REQ-035 reset=0 SHALL immediately force: state ARB, last=1, lock_cnt=0, rdata=0, all rvalid/err=0, all gnt=0, mem strobes/addr/wdata=0; in-flight transfer abandoned; requests ignored until reset=1.

Verification
REQ-036 M0 read 0x10 alone, mem_rdata=0x12345678 -> m0_gnt=1, mem_read=1, mem_addr=0x10; next cycle m0_rvalid=1, rdata=0x12345678.
REQ-037 Both req held, lock=0, after reset -> grants M0,M1,M0,M1...; never both gnt.
REQ-038 MAX_LOCK=8, m1_req=m1_lock=1 for 12 cycles, m0_req=1 -> M1 granted 8 consecutive cycles, M0 1 cycle, M1 resumes.
REQ-039 M1 write 0x40000010 -> m1_gnt=1, mem_write=0; next cycle m1_err=1, then 0.
REQ-040 M0 write 0x40000010, data 0xA5 -> mem_write=1, mem_addr=0x40000010, mem_wdata=0xA5.
REQ-041 reset=0 mid-LOCK -> all outputs 0 same cycle; after release with both requesting, M0 granted first.
